combiner: RTL and testbench
===========================

COMBINER -- requirements
Module: combiner

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, which sets the output FIFO depth in 32-bit words; legal values are 2 and 4.
REQ-002 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port ctl, input, width 2: mode select. 00 = idle, 01 and 10 = single-lane, 11 = dual-lane.
REQ-005 The block SHALL have port Data_In_1, input, width 16: lane 1 halfword.
REQ-006 The block SHALL have port Data_In_2, input, width 16: lane 2 halfword.
REQ-007 The block SHALL have port in_valid, input, width 1: a lane beat is present on Data_In_1 and Data_In_2.
REQ-008 The block SHALL have port in_ready, output, width 1: the block can accept a beat.
REQ-009 The block SHALL have port Data_Out, output, width 32: the reassembled word at the FIFO head.
REQ-010 The block SHALL have port out_valid, output, width 1: Data_Out is valid.
REQ-011 The block SHALL have port out_ready, input, width 1: the consumer takes the word.
REQ-012 The block SHALL have port o_toggle, output, width 1: current lane phase.
REQ-013 The block SHALL have port err_lane, output, width 1: sticky lane-protocol error.

Function
REQ-014 A beat SHALL be accepted when in_valid=1, in_ready=1 and ctl!=00.
REQ-015 in_ready SHALL be 1 only when the FIFO is not full and ctl!=00.
REQ-016 Phase handling:
- phase resets to 0;
- phase toggles on each accepted beat;
- phase is forced to 0 on the cycle after any change of ctl value;
- the ctl-change clear overrides a toggle in the same cycle.
REQ-017 Single-lane mode (01/10), word written to the FIFO:
- phase=1: {16'h0000, Data_In_1};
- phase=0: {16'h0000, Data_In_2}.
REQ-018 In single-lane mode, an accepted beat whose inactive lane is non-zero SHALL set err_lane; the word is still written.
REQ-019 Dual-lane mode (11), word written to the FIFO:
- phase=0: {Data_In_1, Data_In_2};
- phase=1: {Data_In_2, Data_In_1}.
REQ-020 The FIFO SHALL have FIFO_DEPTH entries with wrap-around read and write pointers and an occupancy counter.
REQ-021 Data_Out and out_valid SHALL be driven from the FIFO head; out_valid=1 exactly when the FIFO is non-empty.
REQ-022 Latency from an accepted beat into an empty FIFO to out_valid=1 SHALL be 1 cycle.
REQ-023 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-024 A simultaneous push and pop when full SHALL be impossible because in_ready=0 when full; a pop when full frees one slot, and in_ready=1 on the next cycle.
REQ-025 A simultaneous push and pop when the FIFO is neither empty nor full SHALL leave occupancy unchanged.
REQ-026 When ctl=00:
- no beat is accepted;
- the FIFO continues to drain through out_ready;
- FIFO contents are not flushed.
REQ-027 Data_Out SHALL hold its value while out_valid=1 and out_ready=0.
REQ-028 err_lane SHALL be cleared only by reset.
REQ-029 o_toggle SHALL equal the phase register.

Reset
REQ-030 While rst_n=0, the following SHALL hold regardless of clk:
- phase=0;
- FIFO pointers and occupancy = 0;
- out_valid=0, in_ready=0;
- Data_Out=32'h0;
- err_lane=0;
- the registered previous-ctl value = 00.
REQ-031 Deassertion of rst_n SHALL take effect on the next rising edge of clk.
REQ-032 rst_n asserted mid-operation SHALL discard all queued words immediately, with out_valid=0 in the same cycle.

Verification
REQ-033 Dual-lane beats: ctl=11, beats (1=ABCD, 2=1234) then (1=5678, 2=9EF0), out_ready=1 -> Data_Out 32'hABCD1234 then 32'h9EF05678, o_toggle 1 then 0.
REQ-034 Single-lane beats: ctl=01, beats (1=0000, 2=00AA) then (1=00BB, 2=0000) -> 32'h000000AA then 32'h000000BB, err_lane=0.
REQ-035 Inactive-lane error: ctl=01, phase 0, beat (1=0001, 2=0055) -> word 32'h00000055 and err_lane=1; err_lane stays 1 after ctl=00.
REQ-036 Backpressure: out_ready=0, FIFO_DEPTH=2, three beats offered -> two accepted, in_ready=0; out_ready=1 for one cycle -> one pop, third beat accepted next cycle, order preserved.
REQ-037 Mode change: ctl changes 11->01 after one beat -> o_toggle=0 on the following cycle; the next single-lane beat selects lane 2.
REQ-038 Reset mid-stream: rst_n=0 with two queued words -> out_valid=0 and Data_Out=0 asynchronously; after release, the FIFO is empty and in_ready=1 with ctl=11.

Source files
------------

// File: rtl/combiner.sv
// -----------------------------------------------------------------------------
// combiner
//   Reassembles 16-bit lane beats into 32-bit words and queues them in a small
//   output FIFO. Single-lane modes pick one lane per beat. The phase register
//   alternates the pick. Dual-lane mode concatenates both lanes, and the phase
//   register swaps their order on alternate beats.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   ctl[1:0]   : 00 idle, 01/10 single-lane, 11 dual-lane
//   Data_In_1  : lane 1 halfword
//   Data_In_2  : lane 2 halfword
//   in_valid   : a lane beat is present
//   in_ready   : the block can accept a beat
//   Data_Out   : word at the FIFO head (0 when the FIFO is empty)
//   out_valid  : FIFO is non-empty
//   out_ready  : consumer takes the head word
//   o_toggle   : current lane phase
//   err_lane   : sticky error, set when an inactive lane is non-zero
// -----------------------------------------------------------------------------
module combiner #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ctl,
    input  logic [15:0] Data_In_1,
    input  logic [15:0] Data_In_2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] Data_Out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        o_toggle,
    output logic        err_lane
);

    // Legal depths are 2 and 4. Both are powers of two, so the pointers wrap
    // naturally on overflow.
    localparam int AW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic          r_phase;
    logic [1:0]    r_prev_ctl;
    logic          r_err;
    logic          r_active;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_ctl_chg;
    logic [31:0]   w_word;
    logic          w_lane_err;

    // Assemble the word written to the FIFO from the mode, phase and lanes.
    function automatic logic [31:0] assemble(input logic [1:0]  mode,
                                             input logic        phase,
                                             input logic [15:0] d1,
                                             input logic [15:0] d2);
        logic [31:0] word;
        if (mode == 2'b11)
            word = phase ? {d2, d1} : {d1, d2};
        else
            word = phase ? {16'h0000, d1} : {16'h0000, d2};
        return word;
    endfunction

    // In single-lane mode, the lane not selected by the phase must be zero.
    function automatic logic inactive_nonzero(input logic [1:0]  mode,
                                              input logic        phase,
                                              input logic [15:0] d1,
                                              input logic [15:0] d2);
        logic bad;
        if (mode == 2'b01 || mode == 2'b10)
            bad = phase ? (d2 != 16'h0000) : (d1 != 16'h0000);
        else
            bad = 1'b0;
        return bad;
    endfunction

    assign w_full     = (r_count == DEPTH_C);
    // r_active gates in_ready low until the first clock edge after reset release.
    assign in_ready   = r_active && !w_full && (ctl != 2'b00);
    assign w_push     = in_valid && in_ready;
    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid && out_ready;
    assign w_ctl_chg  = (ctl != r_prev_ctl);
    assign w_word     = assemble(ctl, r_phase, Data_In_1, Data_In_2);
    assign w_lane_err = inactive_nonzero(ctl, r_phase, Data_In_1, Data_In_2);

    // The empty-FIFO mux makes Data_Out read 0 as soon as reset clears the count.
    assign Data_Out   = out_valid ? r_mem[r_rd_ptr] : 32'h0;
    assign o_toggle   = r_phase;
    assign err_lane   = r_err;

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_phase    <= 1'b0;
            r_prev_ctl <= 2'b00;
            r_err      <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_active   <= 1'b1;
            r_prev_ctl <= ctl;

            // A ctl change clears the phase, even if a beat is accepted in the same cycle.
            if (w_ctl_chg)
                r_phase <= 1'b0;
            else if (w_push)
                r_phase <= ~r_phase;

            if (w_push && w_lane_err)
                r_err <= 1'b1;

            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage. Reset does not clear it: Data_Out is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_word;
    end

endmodule

// File: tb/tb_combiner.sv
module tb_combiner;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ctl;
    logic [15:0] Data_In_1;
    logic [15:0] Data_In_2;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Data_Out;
    logic        out_valid;
    logic        out_ready;
    logic        o_toggle;
    logic        err_lane;

    combiner #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctl       (ctl),
        .Data_In_1 (Data_In_1),
        .Data_In_2 (Data_In_2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Data_Out  (Data_Out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o_toggle  (o_toggle),
        .err_lane  (err_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of words plus phase, previous ctl, error and ready state.
    logic [31:0] m_q[$];
    logic        m_phase;
    logic [1:0]  m_prev;
    logic        m_err;
    logic        m_active;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase  = 1'b0;
        m_prev   = 2'b00;
        m_err    = 1'b0;
        m_active = 1'b0;
    endtask

    function automatic logic [31:0] ref_word(input logic [1:0] c, input logic ph,
                                             input logic [15:0] a, input logic [15:0] b);
        if (c == 2'b11) return ph ? {b, a} : {a, b};
        return ph ? {16'h0000, a} : {16'h0000, b};
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_q.size() != 0});
        chk({tag, ".Data_Out"}, Data_Out, (m_q.size() != 0) ? m_q[0] : 32'h0);
        chk({tag, ".o_toggle"}, {31'd0, o_toggle}, {31'd0, m_phase});
        chk({tag, ".err_lane"}, {31'd0, err_lane}, {31'd0, m_err});
    endtask

    // Runs one cycle. It is called at a negedge: it drives the inputs, checks
    // in_ready, advances the model across the posedge, then checks the outputs at
    // the next negedge.
    task automatic step(input string tag, input logic [1:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic iv, input logic ordy);
        logic exp_rdy, push, pop;
        ctl = c; Data_In_1 = a; Data_In_2 = b; in_valid = iv; out_ready = ordy;
        #1;
        exp_rdy = m_active && (m_q.size() < DEPTH) && (c != 2'b00);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
        push = iv && exp_rdy;
        pop  = (m_q.size() != 0) && ordy;
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(ref_word(c, m_phase, a, b));
            if ((c == 2'b01 || c == 2'b10) && ((m_phase ? b : a) != 16'h0000))
                m_err = 1'b1;
        end
        if (c != m_prev) m_phase = 1'b0;
        else if (push)   m_phase = ~m_phase;
        m_prev   = c;
        m_active = 1'b1;
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic [1:0] rc;
        model_reset();
        rst_n = 1'b0; ctl = 2'b11; Data_In_1 = '0; Data_In_2 = '0;
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset state, with ctl=11 held.
        repeat (2) @(negedge clk);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
        check_outputs("rst");

        rst_n = 1'b1;
        step("idle11", 2'b11, 16'h0, 16'h0, 1'b0, 1'b1);

        // Dual-lane beats.
        step("dual1", 2'b11, 16'hABCD, 16'h1234, 1'b1, 1'b1);
        chk("dual1.word", Data_Out, 32'hABCD1234);
        chk("dual1.tog", {31'd0, o_toggle}, 32'd1);
        step("dual2", 2'b11, 16'h5678, 16'h9EF0, 1'b1, 1'b1);
        chk("dual2.word", Data_Out, 32'h9EF05678);
        chk("dual2.tog", {31'd0, o_toggle}, 32'd0);
        step("drain0", 2'b11, 16'h0, 16'h0, 1'b0, 1'b1);

        // Single-lane beats.
        step("sl.chg", 2'b01, 16'h0, 16'h0, 1'b0, 1'b1);
        step("sl1", 2'b01, 16'h0000, 16'h00AA, 1'b1, 1'b1);
        chk("sl1.word", Data_Out, 32'h000000AA);
        step("sl2", 2'b01, 16'h00BB, 16'h0000, 1'b1, 1'b1);
        chk("sl2.word", Data_Out, 32'h000000BB);
        chk("sl2.err", {31'd0, err_lane}, 32'd0);
        step("drain1", 2'b01, 16'h0, 16'h0, 1'b0, 1'b1);

        // Mode change from 11 to 01 after one beat.
        step("mc.chg11", 2'b11, 16'h0, 16'h0, 1'b0, 1'b1);
        step("mc.beat", 2'b11, 16'h1111, 16'h2222, 1'b1, 1'b1);
        chk("mc.tog1", {31'd0, o_toggle}, 32'd1);
        step("mc.chg01", 2'b01, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("mc.tog0", {31'd0, o_toggle}, 32'd0);
        step("mc.sl", 2'b01, 16'h0000, 16'h0033, 1'b1, 1'b1);
        chk("mc.word", Data_Out, 32'h00000033);

        // Inactive-lane error, starting from phase 0.
        step("er.idle", 2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
        step("er.chg", 2'b01, 16'h0, 16'h0, 1'b0, 1'b1);
        step("er.beat", 2'b01, 16'h0001, 16'h0055, 1'b1, 1'b1);
        chk("er.word", Data_Out, 32'h00000055);
        chk("er.err", {31'd0, err_lane}, 32'd1);
        step("er.ctl00", 2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("er.sticky", {31'd0, err_lane}, 32'd1);

        // Backpressure with a full FIFO.
        step("bp.chg", 2'b11, 16'h0, 16'h0, 1'b0, 1'b1);
        step("bp.b1", 2'b11, 16'hA001, 16'hB001, 1'b1, 1'b0);
        step("bp.b2", 2'b11, 16'hA002, 16'hB002, 1'b1, 1'b0);
        step("bp.b3full", 2'b11, 16'hA003, 16'hB003, 1'b1, 1'b0);
        step("bp.pop", 2'b11, 16'hA003, 16'hB003, 1'b1, 1'b1);
        step("bp.b3", 2'b11, 16'hA003, 16'hB003, 1'b1, 1'b0);
        step("bp.d1", 2'b11, 16'h0, 16'h0, 1'b0, 1'b1);
        step("bp.d2", 2'b11, 16'h0, 16'h0, 1'b0, 1'b1);

        // Reset mid-stream with two words queued.
        step("rs.b1", 2'b11, 16'hC001, 16'hD001, 1'b1, 1'b0);
        step("rs.b2", 2'b11, 16'hC002, 16'hD002, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rs.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rs.Data_Out", Data_Out, 32'h0);
        chk("rs.err", {31'd0, err_lane}, 32'd0);
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step("rs.rel", 2'b11, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("rs.in_ready", {31'd0, in_ready}, 32'd1);

        // Randomized traffic.
        rc = 2'b11;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rc = 2'($urandom_range(0, 3));
            step("rand", rc,
                 ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0,
                 ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
